// File: rtl/core_pkg.sv
// Shared types for the 16-bit 5-stage core: opcodes, forwarding-select codes,
// sequencer states and the hazard scoreboard slot.
package core_pkg;

  localparam int unsigned REG_IDX_W_MAX = 8;

  typedef enum logic [3:0] {
    OP_NOP   = 4'b0000,
    OP_ADD   = 4'b0001,
    OP_SUB   = 4'b0010,
    OP_AND   = 4'b0011,
    OP_OR    = 4'b0100,
    OP_XOR   = 4'b0101,
    OP_SHL   = 4'b0110,
    OP_SHR   = 4'b0111,
    OP_ADDI  = 4'b1000,
    OP_BEQ   = 4'b1001,
    OP_BNE   = 4'b1010,
    OP_JMP   = 4'b1011,
    OP_LOAD  = 4'b1100,
    OP_LOADI = 4'b1101,
    OP_STORE = 4'b1110,
    OP_MOV   = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_RSVD  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    FLUSH    = 2'b01,
    MEM_WAIT = 2'b10
  } state_e;

  typedef struct packed {
    logic                     valid;
    logic [REG_IDX_W_MAX-1:0] dest;
    logic                     writes;
    logic                     is_load;
    logic                     is_mem;
  } slot_t;

endpackage

// File: rtl/hazard_fwd_mux.sv
// Forwarding select for one EX operand, evaluated against the slots the
// consuming instruction will see once it has advanced into EX.
module hazard_fwd_mux
  import core_pkg::*;
(
  input  logic [REG_IDX_W_MAX-1:0] src_i,
  input  logic                     rd_en_i,
  input  slot_t                    mem_slot_i,
  input  slot_t                    wb_slot_i,
  output logic [1:0]               sel_o
);

  logic mem_hit;
  logic wb_hit;
  logic unused_slot_bits;

  // A load heading into EX/MEM has no result yet; load-use stalling covers it.
  assign mem_hit = mem_slot_i.valid & mem_slot_i.writes & ~mem_slot_i.is_load &
                   rd_en_i & (mem_slot_i.dest == src_i);
  assign wb_hit  = wb_slot_i.valid & wb_slot_i.writes &
                   rd_en_i & (wb_slot_i.dest == src_i);

  assign unused_slot_bits = ^{mem_slot_i.is_mem, wb_slot_i.is_load, wb_slot_i.is_mem};

  always_comb begin
    sel_o = FWD_RF;
    if (mem_hit) begin
      sel_o = FWD_EXMEM;
    end else if (wb_hit) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: scoreboard, stall/bubble/flush/freeze control and
// operand forwarding selects. Optional perf counters via HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned REG_IDX_W    = 5,
  parameter int unsigned OP_W         = 4,
  parameter int unsigned FLUSH_CYCLES = 2
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [OP_W-1:0]      id_opcode,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_rd1_en,
  input  logic                 id_rd2_en,
  input  logic [REG_IDX_W-1:0] id_dest,
  input  logic                 id_writes,
  input  logic                 ex_taken,
  input  logic                 mem_ready,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 bubble_ex,
  output logic                 freeze,
  output logic                 flush_if_id,
  output logic [1:0]           fwd_sel_a,
  output logic [1:0]           fwd_sel_b,
  output logic                 busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]          perf_stall_cnt,
  output logic [15:0]          perf_flush_cnt,
  output logic [15:0]          perf_wait_cnt
`endif
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  slot_t                    ex_q, mem_q, wb_q;
  slot_t                    ex_d, mem_d, wb_d;
  slot_t                    id_slot;
  logic [REG_IDX_W_MAX-1:0] src1_w, src2_w;
  logic                     mem_wait, load_use, run_like, flush_act;
  logic [1:0]               sel_a, sel_b;

  assign src1_w = REG_IDX_W_MAX'(id_src1);
  assign src2_w = REG_IDX_W_MAX'(id_src2);

  always_comb begin
    id_slot         = '0;
    id_slot.valid   = 1'b1;
    id_slot.dest    = REG_IDX_W_MAX'(id_dest);
    id_slot.writes  = id_writes;
    id_slot.is_load = (id_opcode == OP_W'(OP_LOAD));
    id_slot.is_mem  = (id_opcode == OP_W'(OP_LOAD)) | (id_opcode == OP_W'(OP_STORE));
  end

  assign mem_wait = mem_q.valid & mem_q.is_mem & ~mem_ready;
  assign load_use = ex_q.valid & ex_q.is_load & ex_q.writes & id_valid &
                    ((id_rd1_en & (ex_q.dest == src1_w)) |
                     (id_rd2_en & (ex_q.dest == src2_w)));
  // The cycle mem_ready rises out of MEM_WAIT behaves as the first RUN cycle.
  assign run_like  = (state_q == RUN) | ((state_q == MEM_WAIT) & mem_ready);
  assign flush_act = (run_like & ex_taken) | (state_q == FLUSH);

  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    freeze      = 1'b0;
    flush_if_id = 1'b0;
    busy        = 1'b0;
    fwd_sel_a   = '0;
    fwd_sel_b   = '0;
    if (!rst) begin
      busy      = (state_q != RUN);
      fwd_sel_a = sel_a;
      fwd_sel_b = sel_b;
      if (mem_wait) begin
        freeze   = 1'b1;
        stall_if = 1'b1;
        stall_id = 1'b1;
      end else if (flush_act) begin
        flush_if_id = 1'b1;
        bubble_ex   = 1'b1;
      end else if (load_use) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = (id_valid & ~bubble_ex) ? id_slot : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
        end else if (ex_taken && (FLUSH_CYCLES > 1)) begin
          state_d = FLUSH;
          cnt_d   = CNT_INIT;
        end
      end
      FLUSH: begin
        if (!mem_wait) begin
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          if (ex_taken && (FLUSH_CYCLES > 1)) begin
            state_d = FLUSH;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  // Selects are latched into ID/EX with the instruction, so they look at post-advance slots.
  hazard_fwd_mux u_fwd_a (
    .src_i      (src1_w),
    .rd_en_i    (id_rd1_en),
    .mem_slot_i (mem_d),
    .wb_slot_i  (wb_d),
    .sel_o      (sel_a)
  );

  hazard_fwd_mux u_fwd_b (
    .src_i      (src2_w),
    .rd_en_i    (id_rd2_en),
    .mem_slot_i (mem_d),
    .wb_slot_i  (wb_d),
    .sel_o      (sel_b)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] perf_stall_q, perf_flush_q, perf_wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      if (bubble_ex && !flush_if_id && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 16'd1;
      if (flush_if_id && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 16'd1;
      if (freeze && (perf_wait_q != '1)) perf_wait_q <= perf_wait_q + 16'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_wait_cnt  = perf_wait_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 16-bit 5-stage core: IF, ID, EX, MEM, WB.
- Tracks destination registers in flight through EX/MEM/WB.
- Drives the operand-forwarding selects feeding the execute stage.
- Sequences stalls, bubbles and branch flushes, and freezes the pipe while the data memory is not ready.

Parameters:
- REG_IDX_W, 5: register index width.
- OP_W, 4: opcode width.
- FLUSH_CYCLES, 2: cycles flush_if_id is held after a taken branch (must be ≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  OP_W  ID opcode (LOAD=4'b1100, STORE=4'b1110, LOADI=4'b1101)
- id_src1  in  REG_IDX_W  first source index
- id_src2  in  REG_IDX_W  second source index
- id_rd1_en  in  1  src1 is read
- id_rd2_en  in  1  src2 is read
- id_dest  in  REG_IDX_W  destination index
- id_writes  in  1  instruction writes the register file
- ex_taken  in  1  EX resolved a taken jump this cycle
- mem_ready  in  1  data memory completes this cycle
- stall_if  out  1  hold PC/IF
- stall_id  out  1  hold IF/ID register
- bubble_ex  out  1  load a NOP into ID/EX
- freeze  out  1  hold EX/MEM and MEM/WB
- flush_if_id  out  1  squash IF and ID contents
- fwd_sel_a  out  2  EX operand A source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 reserved
- fwd_sel_b  out  2  EX operand B source, same encoding as fwd_sel_a
- busy  out  1  state ≠ RUN

Behaviour:
- Scoreboard: three slots, EX/MEM/WB. Each slot holds valid, dest, writes, is_load, is_mem.
- Advance: when freeze=0 the slots shift WB←MEM←EX. EX←ID fields if id_valid and !bubble_ex; otherwise EX←invalid.
- Definitions:
  - mem_wait = mem.valid & mem.is_mem & !mem_ready.
  - load_use = ex.valid & ex.is_load & ex.writes & id_valid & ((id_rd1_en & ex.dest==id_src1) | (id_rd2_en & ex.dest==id_src2)).
- Priority, highest first:
  - mem_wait: freeze=stall_if=stall_id=1; bubble=flush=0.
  - Flush (ex_taken in RUN, or state FLUSH): flush_if_id=1, bubble_ex=1.
  - load_use: stall_if=stall_id=bubble_ex=1 for exactly one cycle. The load then sits in MEM and is forwarded from MEM/WB next-next cycle.
- Forwarding selects:
  - Computed combinationally from the scoreboard slot one stage ahead of the consuming instruction.
  - Youngest match wins: MEM-slot match → 01, else WB-slot match → 10, else 00.
  - A slot matches only when valid & writes & dest==src & rd_en.
  - A load in the EX/MEM slot never yields 01.
- FSM states:
  - RUN → MEM_WAIT on mem_wait.
  - RUN → FLUSH on ex_taken when FLUSH_CYCLES>1, with cnt←FLUSH_CYCLES-2.
  - FLUSH: decrement cnt each cycle; → RUN at cnt==0. A new ex_taken is ignored (EX holds a bubble). A mem_wait in FLUSH freezes the counter.
  - MEM_WAIT → RUN on mem_ready.
  - ex_taken during MEM_WAIT is acted on in the first RUN cycle; the datapath holds it because EX is frozen.
- Reset:
  - All slots invalid, state RUN, cnt 0.
  - All outputs 0 while rst=1, including mid-flush and mid-wait.
- Latency: every control output is combinational from current state, slots and inputs, with zero-cycle response. All state updates on the rising clk edge.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs perf_stall_cnt[15:0], perf_flush_cnt[15:0] and perf_wait_cnt[15:0].
  - These are saturating counters of load-use stall cycles, flush cycles and mem_wait cycles.
  - Cleared by rst.
- Undefined: ports and counters are absent, and core behaviour is identical.

Decomposition:
- Shared package core_pkg holds:
  - Opcode constants: NOP…MOV, 4-bit.
  - The fwd_sel encoding constants.
  - The FSM state typedef (RUN, FLUSH, MEM_WAIT).
  - The scoreboard-slot struct typedef.
- One sub-module, hazard_fwd_mux: the pure combinational forwarding-select logic, instantiated twice (operand A and operand B).

Test Plan:
- ADD r3 then SUB r4,r3,r1 back-to-back → fwd_sel_a=01 on the SUB's EX cycle; stall_if=0.
- LOAD r5 then ADD r6,r5,r2 → one cycle stall_if=stall_id=bubble_ex=1, then fwd_sel_a=10; no second stall.
- ex_taken pulse with FLUSH_CYCLES=2 → flush_if_id=1 for 2 consecutive cycles and busy=1 for 1 cycle. Retest with FLUSH_CYCLES=1: 1 cycle, busy stays 0.
- STORE in MEM with mem_ready low for 3 cycles → freeze=stall_if=1 for 3 cycles; slots unchanged; next cycle advances.
- ex_taken and mem_wait in the same cycle → freeze only. Flush starts the cycle mem_ready rises, in the first RUN cycle.
- rst asserted in FLUSH with cnt=1 → next cycle state RUN, all outputs 0, slots invalid; a following dependent ADD yields fwd 00.
